// File: rtl/fir_pkg.sv
// fir_pkg: widths, capture-state type and the round/saturate helper shared by the FIR output path
package fir_pkg;
  localparam int FIR_OUT_W = 16;
  localparam int BUF_OUT_W = 12;
  localparam int BUF_SHIFT = 4;
  typedef enum logic {CAP_IDLE, CAP_WAIT} cap_state_t;
  // Round half up at bit 'shift', then clamp to a signed out_w-bit range; 32-bit math cannot wrap
  function automatic logic signed [31:0] round_sat(input logic signed [31:0] x, input int shift, input int out_w);
    logic signed [31:0] t, hi, lo;
    t = (x + (32'sd1 <<< (shift - 1))) >>> shift;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    return t > hi ? hi : t < lo ? lo : t;
  endfunction
endpackage

// File: rtl/fir_out_buffer_if.sv
// fir_out_buffer_if: consumer-side stream of the FIR output buffer (valid/ready, level, overflow)
interface fir_out_buffer_if import fir_pkg::*; #(parameter int OUT_W = BUF_OUT_W, parameter int DEPTH_LOG2 = 3);
  logic oValid;
  logic [OUT_W-1:0] oData;
  logic iReady;
  logic [DEPTH_LOG2:0] oLevel;
  logic oOvf;
  logic iOvfClr;
  modport master (output oValid, oData, oLevel, oOvf, input iReady, iOvfClr);
  modport slave (input oValid, oData, oLevel, oOvf, output iReady, iOvfClr);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: wrap-bit pointer FIFO with a registered head word and registered level
module sync_fifo #(parameter int W = 12, parameter int DL = 3) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         full,
  output logic [DL:0]  level
);
  logic [W-1:0] mem [2**DL];
  logic [DL:0] wptr, rptr, nrptr, nwptr;
  logic wr;
  assign full = (wptr ^ rptr) == {1'b1, {DL{1'b0}}};
  assign wr = push & (~full | pop);
  assign nrptr = rptr + (DL+1)'(pop);
  assign nwptr = wptr + (DL+1)'(wr);
  always_ff @(posedge clk)
    if (wr) mem[wptr[DL-1:0]] <= wdata;
  // Head loads the incoming word when it becomes the oldest entry, else the next stored one on pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      valid <= 1'b0;
      head <= '0;
    end else begin
      wptr <= nwptr;
      rptr <= nrptr;
      level <= level + (DL+1)'(wr) - (DL+1)'(pop);
      valid <= nwptr != nrptr;
      if (wr && nrptr == wptr) head <= wdata;
      else if (pop) head <= mem[nrptr[DL-1:0]];
    end
endmodule

// File: rtl/fir_out_buffer.sv
// fir_out_buffer: delayed capture of the FIR output per sample strobe, round/saturate, queue to consumer
module fir_out_buffer import fir_pkg::*; #(
  parameter int IN_W = FIR_OUT_W,
  parameter int OUT_W = BUF_OUT_W,
  parameter int SHIFT = BUF_SHIFT,
  parameter int DEPTH_LOG2 = 3,
  parameter int CAP_DLY = 2
) (
  input  logic                   iClk_12M,
  input  logic                   iRsn,
  input  logic                   iEnSample_300k,
  input  logic                   iEnable,
  input  logic signed [IN_W-1:0] iFirOut,
  fir_out_buffer_if.master       bus
);
  cap_state_t state;
  logic [3:0] cnt;
  logic push, pop, full;
  logic [OUT_W-1:0] word;
  assign push = state == CAP_WAIT && iEnable && !iEnSample_300k && cnt == 4'd0;
  assign pop = bus.oValid & bus.iReady;
  assign word = OUT_W'(round_sat(32'(iFirOut), SHIFT, OUT_W));
  // A fresh strobe always reloads the delay, abandoning any pending capture
  always_ff @(posedge iClk_12M or negedge iRsn)
    if (!iRsn) begin
      state <= CAP_IDLE;
      cnt <= 4'd0;
    end else if (!iEnable) state <= CAP_IDLE;
    else if (iEnSample_300k) begin
      state <= CAP_WAIT;
      cnt <= 4'(CAP_DLY - 1);
    end else if (state == CAP_WAIT) begin
      if (cnt == 4'd0) state <= CAP_IDLE;
      else cnt <= cnt - 4'd1;
    end
  always_ff @(posedge iClk_12M or negedge iRsn)
    if (!iRsn) bus.oOvf <= 1'b0;
    else if (push & full & ~pop) bus.oOvf <= 1'b1;
    else if (bus.iOvfClr) bus.oOvf <= 1'b0;
  sync_fifo #(.W(OUT_W), .DL(DEPTH_LOG2)) u_fifo (
    .clk(iClk_12M),
    .rst_n(iRsn),
    .push(push),
    .pop(pop),
    .wdata(word),
    .head(bus.oData),
    .valid(bus.oValid),
    .full(full),
    .level(bus.oLevel)
  );
endmodule

// File: tb/tb_fir_out_buffer.sv
// tb_fir_out_buffer: directed checks of capture delay, rounding, FIFO order, overflow and reset
module tb_fir_out_buffer;
  logic clk = 1'b0;
  logic rst_n, stb, en;
  logic [15:0] fir;
  int tests = 0;
  int failed = 0;
  fir_out_buffer_if #(.OUT_W(12), .DEPTH_LOG2(3)) bus ();
  fir_out_buffer #(.IN_W(16), .OUT_W(12), .SHIFT(4), .DEPTH_LOG2(3), .CAP_DLY(2)) dut (
    .iClk_12M(clk),
    .iRsn(rst_n),
    .iEnSample_300k(stb),
    .iEnable(en),
    .iFirOut(fir),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_one(input logic [15:0] v);
    fir = v;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask
  task automatic pop_one();
    bus.iReady = 1'b1;
    @(negedge clk);
    bus.iReady = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    stb = 1'b0;
    en = 1'b0;
    fir = '0;
    bus.iReady = 1'b0;
    bus.iOvfClr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.oValid, 0);
    chk("rst_data", bus.oData, 0);
    chk("rst_level", bus.oLevel, 0);
    chk("rst_ovf", bus.oOvf, 0);
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk);
    fir = 16'h0123;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    chk("lat_e0_valid", bus.oValid, 0);
    @(negedge clk);
    chk("lat_e1_valid", bus.oValid, 0);
    @(negedge clk);
    chk("lat_e2_valid", bus.oValid, 1);
    chk("lat_e2_data", bus.oData, 12'h012);
    chk("lat_e2_level", bus.oLevel, 1);
    pop_one();
    chk("pop_valid", bus.oValid, 0);
    chk("pop_level", bus.oLevel, 0);
    push_one(16'h7FFF);
    chk("sat_pos", bus.oData, 12'h7FF);
    pop_one();
    push_one(16'h8000);
    chk("sat_neg", bus.oData, 12'h800);
    pop_one();
    push_one(16'hFFF8);
    chk("tie_neg", bus.oData, 12'h000);
    pop_one();
    push_one(16'hFFF7);
    chk("rnd_neg", bus.oData, 12'hFFF);
    pop_one();
    for (int k = 1; k <= 9; k++) push_one(16'(k * 256));
    chk("ovf_level", bus.oLevel, 8);
    chk("ovf_flag", bus.oOvf, 1);
    chk("ovf_head", bus.oData, 12'h010);
    bus.iOvfClr = 1'b1;
    @(negedge clk);
    bus.iOvfClr = 1'b0;
    chk("ovf_clr", bus.oOvf, 0);
    bus.iReady = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain_%0d", k), bus.oData, 32'(k * 16));
      @(negedge clk);
    end
    bus.iReady = 1'b0;
    chk("drain_valid", bus.oValid, 0);
    chk("drain_level", bus.oLevel, 0);
    for (int k = 1; k <= 8; k++) push_one(16'(k * 16));
    chk("fill_level", bus.oLevel, 8);
    fir = 16'h0090;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    @(negedge clk);
    bus.iReady = 1'b1;
    @(negedge clk);
    bus.iReady = 1'b0;
    chk("fullpop_level", bus.oLevel, 8);
    chk("fullpop_ovf", bus.oOvf, 0);
    chk("fullpop_head", bus.oData, 12'h002);
    bus.iReady = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("fullpop_drain_%0d", k), bus.oData, 32'(k));
      @(negedge clk);
    end
    bus.iReady = 1'b0;
    chk("fullpop_empty", bus.oValid, 0);
    fir = 16'h0AA0;
    stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stb = 1'b0;
    @(negedge clk);
    chk("restart_early", bus.oLevel, 0);
    fir = 16'h0BB0;
    @(negedge clk);
    chk("restart_level", bus.oLevel, 1);
    chk("restart_data", bus.oData, 12'h0BB);
    repeat (4) @(negedge clk);
    chk("restart_once", bus.oLevel, 1);
    pop_one();
    en = 1'b0;
    push_one(16'h0555);
    @(negedge clk);
    chk("disabled_level", bus.oLevel, 0);
    en = 1'b1;
    for (int k = 1; k <= 3; k++) push_one(16'(k * 32));
    chk("pre_rst_level", bus.oLevel, 3);
    fir = 16'h0300;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.oValid, 0);
    chk("arst_level", bus.oLevel, 0);
    chk("arst_ovf", bus.oOvf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_level", bus.oLevel, 0);
    chk("post_rst_valid", bus.oValid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
